// File: rtl/cavlc_stream_packer_if.sv
// Handshake bundle between the CAVLC encoder channels, the packer and the
// slice/NAL writer. master = stimulus/encoder side, slave = packer.
interface cavlc_stream_packer_if #(
    parameter int N_CH  = 2,
    parameter int IN_W  = 128,
    parameter int LEN_W = $clog2(IN_W + 1),
    parameter int OUT_W = 32
);
    logic [N_CH-1:0]            in_valid;
    logic [N_CH-1:0]            in_ready;
    logic [N_CH-1:0][IN_W-1:0]  in_code;
    logic [N_CH-1:0][LEN_W-1:0] in_len;
    logic                       flush_req;
    logic                       flush_ack;
    logic                       out_valid;
    logic                       out_ready;
    logic [OUT_W-1:0]           out_word;
    logic                       out_last;
    logic [31:0]                total_bits;
    logic                       err_len;

    modport master (
        output in_valid, in_code, in_len, flush_req, out_ready,
        input  in_ready, flush_ack, out_valid, out_word, out_last, total_bits, err_len
    );

    modport slave (
        input  in_valid, in_code, in_len, flush_req, out_ready,
        output in_ready, flush_ack, out_valid, out_word, out_last, total_bits, err_len
    );
endinterface

// File: rtl/cavlc_stream_packer.sv
// CAVLC bitstream packer: round-robin merges right-aligned variable-length
// segments from N_CH channels into MSB-first OUT_W-bit words, with an
// RBSP-style stop-bit flush to a word boundary.
module cavlc_stream_packer #(
    parameter int IN_W     = 128,
    parameter int LEN_W    = $clog2(IN_W + 1),
    parameter int OUT_W    = 32,
    parameter int N_CH     = 2,
    parameter bit PAD_STOP = 1'b1
) (
    input logic                  clk,
    input logic                  rst,
    cavlc_stream_packer_if.slave bus
);
    localparam int ACC_W = IN_W + OUT_W;
    localparam int CNT_W = $clog2(ACC_W + 1);
    localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [CNT_W-1:0] OUT_W_C  = CNT_W'(OUT_W);
    localparam logic [ACC_W-1:0] STOP_MSB = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {RUN, FDRAIN, FLAST, ACK} state_t;

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]  rr_q;
    logic [31:0]       total_q;
    logic              err_q;
    logic              out_valid_q, out_last_q, ack_q;
    logic              out_valid_d;

    logic              gnt_vld;
    logic [PTR_W-1:0]  gnt_idx;
    logic              accept_ok, take, emit;
    logic [IN_W-1:0]   seg_code, seg_mask;
    logic [LEN_W-1:0]  seg_len_raw, seg_len;
    logic              len_over;
    logic [ACC_W-1:0]  seg_ext;
    logic [CNT_W-1:0]  seg_sh;

    // Round-robin pick: lowest valid channel at or after rr_q wins, otherwise
    // the lowest valid channel below rr_q (second loop overrides the first).
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int j = N_CH - 1; j >= 0; j--) begin
            if (bus.in_valid[j] && (j < int'(rr_q))) begin
                gnt_vld = 1'b1;
                gnt_idx = PTR_W'(j);
            end
        end
        for (int j = N_CH - 1; j >= 0; j--) begin
            if (bus.in_valid[j] && (j >= int'(rr_q))) begin
                gnt_vld = 1'b1;
                gnt_idx = PTR_W'(j);
            end
        end
    end

    // Input is only taken while there is room below one output word, so a
    // segment of up to IN_W bits always fits in the accumulator.
    assign accept_ok = (state_q == RUN) && (cnt_q < OUT_W_C) && !rst;
    assign take      = accept_ok && gnt_vld;
    assign emit      = out_valid_q && bus.out_ready;

    // One-hot ready toward the granted channel only.
    always_comb begin
        bus.in_ready = '0;
        if (take) bus.in_ready[gnt_idx] = 1'b1;
    end

    assign seg_code    = bus.in_code[gnt_idx];
    assign seg_len_raw = bus.in_len[gnt_idx];
    assign len_over    = seg_len_raw > LEN_W'(IN_W);
    assign seg_len     = len_over ? LEN_W'(IN_W) : seg_len_raw;
    // Shifting all-ones by IN_W yields zero, so a full-length segment keeps every bit.
    assign seg_mask    = ~({IN_W{1'b1}} << seg_len);
    assign seg_ext     = {{OUT_W{1'b0}}, seg_code & seg_mask};
    // Puts the segment MSB directly under the current fill point.
    assign seg_sh      = CNT_W'(ACC_W) - cnt_q - CNT_W'(seg_len);

    // Next-state and accumulator update. Accept and emit never coincide:
    // accept needs cnt < OUT_W, a RUN/FDRAIN emit needs cnt >= OUT_W.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        if (take) begin
            acc_d = acc_q | (seg_ext << seg_sh);
            cnt_d = cnt_q + CNT_W'(seg_len);
        end
        case (state_q)
            RUN: begin
                if (emit) begin
                    acc_d = acc_q << OUT_W;
                    cnt_d = cnt_q - OUT_W_C;
                end
                if (bus.flush_req) state_d = FDRAIN;
            end
            FDRAIN: begin
                if (emit) begin
                    acc_d = acc_q << OUT_W;
                    cnt_d = cnt_q - OUT_W_C;
                end
                if (cnt_d < OUT_W_C) begin
                    if (!PAD_STOP && (cnt_d == '0)) begin
                        state_d = ACK;
                    end else begin
                        // Bits below the fill point are already zero, so only
                        // the stop bit has to be placed for the final word.
                        state_d = FLAST;
                        if (PAD_STOP) acc_d = acc_d | (STOP_MSB >> cnt_d);
                    end
                end
            end
            FLAST: begin
                if (emit) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ACK;
                end
            end
            ACK:     state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Output valid is precomputed from next state so the port is a plain flop.
    assign out_valid_d = (state_d == FLAST) ||
                         (((state_d == RUN) || (state_d == FDRAIN)) && (cnt_d >= OUT_W_C));

    // State, datapath and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            acc_q       <= '0;
            cnt_q       <= '0;
            rr_q        <= '0;
            total_q     <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= (state_d == FLAST);
            ack_q       <= (state_d == ACK);
            if (take) begin
                rr_q    <= (gnt_idx == PTR_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
                total_q <= total_q + 32'(seg_len);
                if (len_over) err_q <= 1'b1;
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_word   = acc_q[ACC_W-1 -: OUT_W];
    assign bus.out_last   = out_last_q;
    assign bus.flush_ack  = ack_q;
    assign bus.total_bits = total_q;
    assign bus.err_len    = err_q;
endmodule

// File: tb/tb_cavlc_stream_packer.sv
// Scoreboard bench for cavlc_stream_packer: a bit-queue model turns driven
// segments and flushes into expected words; a monitor pops and compares.
module tb_cavlc_stream_packer;
    localparam int IN_W     = 128;
    localparam int LEN_W    = $clog2(IN_W + 1);
    localparam int OUT_W    = 32;
    localparam int N_CH     = 2;
    localparam bit PAD_STOP = 1'b1;

    typedef struct {
        logic [OUT_W-1:0] w;
        logic             last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cavlc_stream_packer_if #(.N_CH(N_CH), .IN_W(IN_W), .LEN_W(LEN_W), .OUT_W(OUT_W)) bus();

    cavlc_stream_packer #(
        .IN_W(IN_W), .LEN_W(LEN_W), .OUT_W(OUT_W), .N_CH(N_CH), .PAD_STOP(PAD_STOP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t             exp_q[$];
    bit               mbits[$];
    exp_t             mon_e;
    int               n_chk = 0;
    int               n_err = 0;
    int               cyc = 0;
    int               last_hs_cyc = 0;
    int               tot_exp = 0;
    int               rdy_mode = 0;
    bit               stall_prev = 1'b0;
    logic [OUT_W-1:0] stall_word;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void pop_words(input bit last);
        exp_t e;
        while (mbits.size() >= OUT_W) begin
            e.w = '0;
            for (int i = OUT_W - 1; i >= 0; i--) e.w[i] = mbits.pop_front();
            e.last = last;
            exp_q.push_back(e);
        end
    endfunction

    function automatic void push_seg(input int len, input logic [IN_W-1:0] code);
        int l = (len > IN_W) ? IN_W : len;
        for (int i = l - 1; i >= 0; i--) mbits.push_back(code[i]);
        tot_exp += l;
        pop_words(1'b0);
    endfunction

    function automatic void push_flush();
        if (mbits.size() == 0 && !PAD_STOP) return;
        if (PAD_STOP) mbits.push_back(1'b1);
        while ((mbits.size() % OUT_W) != 0) mbits.push_back(1'b0);
        pop_words(1'b1);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream ready pattern: 0 = always ready, 1 = toggling, 2 = held low.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                1:       bus.out_ready = ~bus.out_ready;
                2:       bus.out_ready = 1'b0;
                default: bus.out_ready = 1'b1;
            endcase
        end
    end

    // Output monitor: scoreboard pop, input blocking while a word is pending, stall stability.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid) chk("rdy_blk", bus.in_ready, 0);
            if (stall_prev && bus.out_valid) chk("stable", bus.out_word, stall_word);
            if (bus.out_valid && bus.out_ready) begin
                chk("sb_avail", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("word", bus.out_word, mon_e.w);
                    chk("last", bus.out_last, mon_e.last);
                end
                if (bus.out_last) last_hs_cyc = cyc;
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            stall_word = bus.out_word;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic send(input int ch, input int len, input logic [IN_W-1:0] code);
        bit got = 1'b0;
        push_seg(len, code);
        bus.in_code[ch]  = code;
        bus.in_len[ch]   = LEN_W'(len);
        bus.in_valid[ch] = 1'b1;
        for (int t = 0; t < 300 && !got; t++) begin
            @(negedge clk);
            got = bus.in_ready[ch];
            @(posedge clk); #1;
        end
        bus.in_valid[ch] = 1'b0;
        chk("accept", got, 1);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic do_flush();
        int t = 0;
        bit seen = 1'b0;
        push_flush();
        bus.flush_req = 1'b1;
        while (!seen && t < 500) begin
            @(negedge clk);
            seen = bus.flush_ack;
            if (!seen) begin
                @(posedge clk); #1;
            end
            t++;
        end
        chk("flush_ack", seen, 1);
        chk("ack_lat", cyc - last_hs_cyc, 1);
        @(posedge clk); #1;
        bus.flush_req = 1'b0;
        @(negedge clk);
        chk("ack_pulse", bus.flush_ack, 0);
        @(posedge clk); #1;
        chk("sb_empty", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int t;
        bus.in_valid  = '0;
        bus.in_code   = '0;
        bus.in_len    = '0;
        bus.flush_req = 1'b0;

        // Reset: request from both channels must not be granted.
        rst = 1'b1;
        bus.in_valid  = 2'b11;
        bus.in_len[0] = LEN_W'(8);
        bus.in_len[1] = LEN_W'(8);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_word", bus.out_word, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_flush_ack", bus.flush_ack, 0);
        chk("rst_total", bus.total_bits, 0);
        chk("rst_err", bus.err_len, 0);
        @(posedge clk); #1;
        bus.in_valid = '0;
        rst = 1'b0;
        @(posedge clk); #1;

        // Arbitration: both channels valid, grants alternate from ch0.
        bus.in_code[0] = IN_W'(8'h11);
        bus.in_code[1] = IN_W'(8'h22);
        for (int k = 0; k < 4; k++) begin
            push_seg(8, IN_W'(8'h11));
            push_seg(8, IN_W'(8'h22));
        end
        bus.in_valid = 2'b11;
        n = 0;
        t = 0;
        while (n < 8 && t < 300) begin
            @(negedge clk);
            if (bus.in_ready != 0) begin
                chk("arb_gnt", bus.in_ready, (n % 2 == 0) ? 2'b01 : 2'b10);
                n++;
            end
            @(posedge clk); #1;
            t++;
        end
        bus.in_valid = '0;
        chk("arb_cnt", n, 8);
        drain();
        chk("arb_total", bus.total_bits, tot_exp);
        do_flush();

        // Single segment then flush.
        send(0, 5, IN_W'(5'b10110));
        do_flush();
        chk("single_total", bus.total_bits, tot_exp);

        // Word crossing.
        send(0, 20, IN_W'(20'hABCDE));
        send(0, 20, IN_W'(20'h12345));
        do_flush();

        // Full-length segment with toggling ready; ch1 waits the whole drain.
        rdy_mode = 1;
        send(0, 128, {IN_W{1'b1}});
        send(1, 0, '0);
        chk("blk_order", exp_q.size(), 0);
        rdy_mode = 0;
        do_flush();

        // Zero length and over-length.
        send(0, 0, IN_W'(8'hFF));
        repeat (3) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("len0_no_word", bus.out_valid, 0);
        chk("len0_total", bus.total_bits, tot_exp);
        chk("len0_err", bus.err_len, 0);
        @(posedge clk); #1;
        send(1, 200, {IN_W{1'b1}});
        chk("err_set", bus.err_len, 1);
        drain();
        send(0, 8, IN_W'(8'hA5));
        do_flush();
        chk("err_sticky", bus.err_len, 1);
        chk("err_total", bus.total_bits, tot_exp);

        // Reset in the middle of a stalled flush with 40 pending bits.
        rdy_mode = 2;
        repeat (2) begin
            @(posedge clk); #1;
        end
        send(0, 40, IN_W'(40'hDEADBEEF12));
        bus.flush_req = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("pre_rst_valid", bus.out_valid, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.in_valid[0] = 1'b1;
        @(posedge clk); #1;
        mbits.delete();
        exp_q.delete();
        tot_exp = 0;
        @(negedge clk);
        chk("mid_rst_in_ready", bus.in_ready, 0);
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_out_word", bus.out_word, 0);
        chk("mid_rst_out_last", bus.out_last, 0);
        chk("mid_rst_ack", bus.flush_ack, 0);
        chk("mid_rst_total", bus.total_bits, 0);
        chk("mid_rst_err", bus.err_len, 0);
        @(posedge clk); #1;
        bus.in_valid  = '0;
        bus.flush_req = 1'b0;
        rdy_mode      = 0;
        rst           = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("no_ack", bus.flush_ack, 0);
            chk("post_rst_idle", bus.out_valid, 0);
            @(posedge clk); #1;
        end
        do_flush();

        chk("sb_final", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
